seq_mul_ctrl: RTL and testbench
===============================

Name: seq_mul_ctrl

Overview:
- Multi-cycle, shift-add sequencer for sign-magnitude multiplication, with a start/busy/done handshake.
- Produces the same result encoding as the combinational `mul` block: WIDTH-bit sign-magnitude operands in, 2*WIDTH-bit two's-complement product out.
- Used in area-constrained paths in place of `mul`, and verified against the same value set.

Parameters:
- WIDTH, 6, operand width. Bit WIDTH-1 is the sign; bits WIDTH-2:0 are the magnitude. Legal range 3..16.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, asynchronous and active-low. One clock; reset is asynchronous and active-low.
- start  input  1  request a multiply; sampled only in IDLE.
- a  input  WIDTH  sign-magnitude multiplicand.
- b  input  WIDTH  sign-magnitude multiplier.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse: `out` is valid from this cycle onward.
- out  output  2*WIDTH  two's-complement product; held until the next done.

Behaviour:
- Reset (rst_n=0, async): state=IDLE, busy=0, done=0, out=0, and all internal registers cleared. This applies mid-operation too: the in-flight operation is discarded and produces no done.
- States: IDLE, CALC, FIX.
- IDLE:
  - On a clk edge with start=1: latch ma=a[WIDTH-2:0], mb=b[WIDTH-2:0] and sgn=a[WIDTH-1]^b[WIDTH-1].
  - Clear the accumulator acc (2*WIDTH-2 bits) and the counter cnt.
  - Go to CALC.
  - start=0: stay in IDLE.
- CALC (WIDTH-1 edges):
  - Each edge: if mb[0], acc += ma shifted left by cnt; then mb >>= 1 and cnt++.
  - At the edge where cnt==WIDTH-2, go to FIX.
- FIX (1 edge):
  - out <= sgn ? -zext(acc) : zext(acc), computed at 2*WIDTH bits.
  - done <= 1; go to IDLE.
- Zero rule: if acc==0, out=0 regardless of sgn. Negative zero inputs (sign=1, magnitude=0) therefore yield out=0.
- done is high for exactly one cycle, the cycle after the FIX edge. It is cleared on the next edge.
- busy=1 in CALC and FIX, 0 in IDLE. busy is registered with the state.
- Latency: start sampled at edge E0 gives done=1 and a valid out in the cycle after edge E0+WIDTH. For WIDTH=6: done is asserted after 6 edges.
- While busy, start is ignored. Changes on a/b are ignored after E0; operands are latched.
- Back-to-back: start=1 in the done cycle is accepted (state is IDLE). done falls and busy rises on the same edge.
- Accumulator never overflows. Max magnitude is (2^(WIDTH-1)-1)^2 < 2^(2*WIDTH-2).
- out is never modified except at the FIX edge and at reset.
- No combinational path from any input to any output.
- Counter width is $clog2(WIDTH).

Test Plan:
- Reset, then a=6'b000011 (3), b=6'b000101 (5), start pulse -> busy for 6 cycles; done one cycle; out=12'h00F; busy=0 in the done cycle.
- a=6'b111111 (-31), b=6'b011111 (+31) -> out=12'hC3F (-961). Then a=-31, b=-31 -> out=12'h3C1 (+961).
- a=6'b100000 (-0), b=6'b100101 (-5) -> out=12'h000. Also a=+7, b=-0 -> out=12'h000.
- Sequencing and reset:
  - start held high and a/b changed during busy -> the first result is unaffected and no second op starts before done.
  - start asserted in the done cycle -> second result arrives 6 cycles later.
  - rst_n pulsed low mid-CALC -> out=0, done never pulses, busy=0 immediately (async).
- Exhaustive sweep of x,y over -31..31 (sign-magnitude encoded) -> out == (x*y) & 12'hFFF for all 3969 pairs, zero errors reported.

Source files
------------

// File: rtl/seq_mul_ctrl.sv
// +--------------------------------------------------------------------------+
// | Module   : seq_mul_ctrl                                                  |
// | Function : shift-add sign-magnitude multiplier, two's-complement result  |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
`default_nettype none

module seq_mul_ctrl #(
  parameter int WIDTH = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] out
);

  localparam int c_cnt_w = $clog2(WIDTH);
  localparam int c_mag_w = WIDTH - 1;
  localparam int c_acc_w = 2 * WIDTH - 2;
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(WIDTH - 2);
  localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [c_mag_w-1:0]   r_ma;
  logic [c_mag_w-1:0]   r_mb;
  logic                 r_sgn;
  logic [c_acc_w-1:0]   r_acc;
  logic [c_cnt_w-1:0]   r_cnt;
  logic                 r_busy;
  logic                 r_done;
  logic [2*WIDTH-1:0]   r_out;
  logic [c_acc_w-1:0]   w_addend;
  logic [2*WIDTH-1:0]   w_ext;
  logic [2*WIDTH-1:0]   w_result;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_CALC;
      S_CALC:  if (r_cnt == c_cnt_last) w_state_nxt = S_FIX;
      S_FIX:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Negating a zero accumulator yields zero, so -0 inputs come out as 0.
  assign w_addend = {{c_mag_w{1'b0}}, r_ma} << r_cnt;
  assign w_ext    = {2'b00, r_acc};
  assign w_result = r_sgn ? -w_ext : w_ext;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ma   <= '0;
      r_mb   <= '0;
      r_sgn  <= 1'b0;
      r_acc  <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_out  <= '0;
    end else begin
      r_busy <= (w_state_nxt != S_IDLE);
      r_done <= (r_state == S_FIX);
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_ma  <= a[WIDTH-2:0];
            r_mb  <= b[WIDTH-2:0];
            r_sgn <= a[WIDTH-1] ^ b[WIDTH-1];
            r_acc <= '0;
            r_cnt <= '0;
          end
        end
        S_CALC: begin
          if (r_mb[0]) r_acc <= r_acc + w_addend;
          r_mb  <= r_mb >> 1;
          r_cnt <= r_cnt + c_cnt_one;
        end
        S_FIX: begin
          r_out <= w_result;
        end
        default: ;
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign out  = r_out;

endmodule

`default_nettype wire

// File: tb/tb_seq_mul_ctrl.sv
// +--------------------------------------------------------------------------+
// | Module   : tb_seq_mul_ctrl                                               |
// | Function : directed and sweep checks of seq_mul_ctrl (WIDTH=6)           |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_seq_mul_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [5:0]  a;
  logic [5:0]  b;
  logic        busy;
  logic        done;
  logic [11:0] out;

  int checks = 0;
  int errors = 0;

  seq_mul_ctrl #(.WIDTH(6)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .out   (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  a;
    logic [5:0]  b;
    logic [11:0] exp;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called at the negedge following the start edge; returns at the done cycle.
  task automatic wait_done(input string name, input bit scramble, output logic [11:0] res);
    int  busy_cyc;
    bit  got;
    busy_cyc = 0;
    got      = 1'b0;
    res      = 'x;
    for (int k = 0; k < 20 && !got; k++) begin
      if (done) begin
        got = 1'b1;
        res = out;
      end else begin
        if (busy) busy_cyc++;
        if (scramble) begin
          a = 6'($urandom);
          b = 6'($urandom);
        end
        @(negedge clk);
      end
    end
    chk({name, " done_seen"}, 32'(got), 32'd1);
    chk({name, " busy_cycles"}, 32'(busy_cyc), 32'd6);
    chk({name, " busy_at_done"}, 32'(busy), 32'd0);
  endtask

  task automatic run_op(input string name, input logic [5:0] ta, input logic [5:0] tb_v,
                        input bit hold, output logic [11:0] res);
    @(negedge clk);
    a     = ta;
    b     = tb_v;
    start = 1'b1;
    @(negedge clk);
    if (!hold) start = 1'b0;
    wait_done(name, hold, res);
    start = 1'b0;
  endtask

  function automatic logic [5:0] sm(input int v);
    logic [4:0] mag;
    mag = (v < 0) ? 5'(-v) : 5'(v);
    return {(v < 0), mag};
  endfunction

  vec_t        vecs[7];
  logic [11:0] res;
  int          prod;
  logic [31:0] pbits;
  bit          saw_done;

  initial begin
    vecs[0] = '{6'b000011, 6'b000101, 12'h00F};
    vecs[1] = '{6'b111111, 6'b011111, 12'hC3F};
    vecs[2] = '{6'b111111, 6'b111111, 12'h3C1};
    vecs[3] = '{6'b100000, 6'b100101, 12'h000};
    vecs[4] = '{6'b000111, 6'b100000, 12'h000};
    vecs[5] = '{6'b000001, 6'b100001, 12'hFFF};
    vecs[6] = '{6'b011111, 6'b000000, 12'h000};

    rst_n = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;
    repeat (2) @(negedge clk);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset out", 32'(out), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, 1'b0, res);
      chk($sformatf("vec%0d out", i), 32'(res), 32'(vecs[i].exp));
      @(negedge clk);
      chk($sformatf("vec%0d done_drop", i), 32'(done), 32'd0);
      chk($sformatf("vec%0d out_hold", i), 32'(out), 32'(vecs[i].exp));
    end

    // start held high and operands scrambled while busy
    run_op("hold", 6'b000011, 6'b000101, 1'b1, res);
    chk("hold out", 32'(res), 32'h00F);
    repeat (2) @(negedge clk);

    // back-to-back: new start in the done cycle
    run_op("b2b1", 6'b000110, 6'b100111, 1'b0, res);
    chk("b2b1 out", 32'(res), 32'hFD6);
    a     = 6'b001001;
    b     = 6'b000100;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("b2b busy_rise", 32'(busy), 32'd1);
    chk("b2b done_fall", 32'(done), 32'd0);
    chk("b2b out_held", 32'(out), 32'hFD6);
    wait_done("b2b2", 1'b0, res);
    chk("b2b2 out", 32'(res), 32'h024);

    // asynchronous reset in the middle of CALC
    @(negedge clk);
    a     = 6'b010101;
    b     = 6'b001011;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst busy", 32'(busy), 32'd0);
    chk("midrst out", 32'(out), 32'd0);
    chk("midrst done", 32'(done), 32'd0);
    @(negedge clk);
    rst_n    = 1'b1;
    saw_done = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (done || busy) saw_done = 1'b1;
    end
    chk("midrst no_activity", 32'(saw_done), 32'd0);

    // exhaustive sweep over -31..31
    for (int x = -31; x <= 31; x++) begin
      for (int y = -31; y <= 31; y++) begin
        run_op("sweep", sm(x), sm(y), 1'b0, res);
        prod  = x * y;
        pbits = 32'(prod);
        if (res !== pbits[11:0]) begin
          $display("FAIL sweep x=%0d y=%0d: got %0h expected %0h", x, y, res, pbits[11:0]);
          errors++;
        end
        checks++;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
